// File: rtl/rv32im_memory_unit.sv
// ---------------------------------------------------------------------------
// rv32im_memory_unit
//
// Runs one load/store from the execute stage out to a Wishbone bus. It asks
// the arbiter for the bus, steers byte lanes for reads and writes, and
// sign- or zero-extends load data. An access that crosses a word boundary
// is either split into two back-to-back beats or rejected with an error.
// A per-beat watchdog aborts a beat that is never acknowledged.
//
// Ports
//   clk_i, rst_n_i            clock, synchronous active-low reset
//   start_i                   request pulse, accepted only while busy_o=0
//   addr_i, data_i            byte address, right-justified store data
//   word_size_i, unsigned_i   00 byte/01 half/10 word/11 double; 1 = zero-extend
//   write_i                   1 = store
//   data_o                    load result, right-justified and extended
//   busy_o, done_o, err_o     in flight / completion pulse / failure pulse
//   err_code_o                00 ok, 01 bus error, 10 timeout, 11 misaligned/illegal
//   master_dat_i/o, ack_i, err_i, adr_o, cyc_o, stb_o, we_o, sel_o   Wishbone
//   ctrl_req_o, ctrl_grant_i  arbiter handshake
// ---------------------------------------------------------------------------
module rv32im_memory_unit #(
  parameter int XLEN             = 32,
  parameter int TIMEOUT_CYCLES   = 255,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           start_i,
  input  logic [XLEN-1:0]                addr_i,
  input  logic [XLEN-1:0]                data_i,
  input  logic [1:0]                     word_size_i,
  input  logic                           unsigned_i,
  input  logic                           write_i,
  output logic [XLEN-1:0]                data_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic [1:0]                     err_code_o,
  input  logic [XLEN-1:0]                master_dat_i,
  output logic [XLEN-1:0]                master_dat_o,
  input  logic                           ack_i,
  input  logic                           err_i,
  output logic [XLEN-$clog2(XLEN/8)-1:0] adr_o,
  output logic                           cyc_o,
  output logic                           stb_o,
  output logic                           we_o,
  output logic [XLEN/8-1:0]              sel_o,
  output logic                           ctrl_req_o,
  input  logic                           ctrl_grant_i
);

  localparam int BYTES = XLEN / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int AW    = XLEN - OFS;
  localparam int MW    = 2 * BYTES;
  // Counter wide enough to hold TIMEOUT_CYCLES itself.
  localparam int CW    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW:0] TO_VAL  = (CW+1)'(TIMEOUT_CYCLES);
  localparam logic [CW:0] CNT_ONE = (CW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BEAT0, S_BEAT1} state_t;

  // Lane mask of an access of the given size, before shifting by the offset.
  function automatic logic [MW-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return MW'(8'h01);
      2'b01:   return MW'(8'h03);
      2'b10:   return MW'(8'h0F);
      default: return MW'(8'hFF);
    endcase
  endfunction

  // True when the access runs past the end of the current bus word.
  function automatic logic crosses(input logic [OFS-1:0] ofs, input logic [1:0] sz);
    return (int'(ofs) + (1 << sz)) > BYTES;
  endfunction

  function automatic logic illegal_size(input logic [1:0] sz);
    return (sz == 2'b11) && (XLEN == 32);
  endfunction

  state_t            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              write_q, write_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   data_o_q, data_o_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [XLEN-1:0]   mdat_q, mdat_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [BYTES-1:0]  sel_q, sel_d;
  logic              req_q, req_d;

  // Datapath derived from the latched request.
  logic [OFS-1:0]    ofs_q;
  logic [MW-1:0]     sel_wide;
  logic [2*XLEN-1:0] dat_wide;
  logic              cross_q;
  logic              reject_in;
  logic [CW:0]       cnt_inc;

  assign ofs_q     = addr_q[OFS-1:0];
  assign cross_q   = crosses(ofs_q, size_q);
  // Low half of the shifted mask/data is beat 0, high half is beat 1.
  assign sel_wide  = size_mask(size_q) << ofs_q;
  assign dat_wide  = {{XLEN{1'b0}}, wdata_q} << {ofs_q, 3'b000};
  assign reject_in = illegal_size(word_size_i) ||
                     (!SPLIT_MISALIGNED && crosses(addr_i[OFS-1:0], word_size_i));
  assign cnt_inc   = {1'b0, cnt_q} + CNT_ONE;

  // Load assembly: on a single-beat access the live bus data is the low
  // word and the high word is zero; after a split, the captured beat-0
  // data is the low word and the live bus data is the high word.
  logic [XLEN-1:0] rd_lo, rd_hi, rd_al, keep, load_val;
  logic            msb;

  always_comb begin
    rd_lo = (state_q == S_BEAT1) ? lo_q : master_dat_i;
    rd_hi = (state_q == S_BEAT1) ? master_dat_i : '0;
    rd_al = XLEN'({rd_hi, rd_lo} >> {ofs_q, 3'b000});
    keep  = '1;
    msb   = 1'b0;
    case (size_q)
      2'b00: begin keep = XLEN'(8'hFF);          msb = rd_al[7];  end
      2'b01: begin keep = XLEN'(16'hFFFF);       msb = rd_al[15]; end
      2'b10: begin keep = XLEN'(32'hFFFF_FFFF);  msb = rd_al[31]; end
      default: begin keep = '1;                  msb = 1'b0;      end
    endcase
    load_val = (rd_al & keep) | ((!uns_q && msb) ? ~keep : '0);
  end

  // Next-state and output logic.
  logic finish, abort;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    uns_d      = uns_q;
    write_d    = write_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    data_o_d   = data_o_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    mdat_d     = mdat_q;
    adr_d      = adr_q;
    stb_d      = stb_q;
    we_d       = we_q;
    sel_d      = sel_q;
    req_d      = req_q;
    finish     = 1'b0;
    abort      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = addr_i;
          wdata_d = data_i;
          size_d  = word_size_i;
          uns_d   = unsigned_i;
          write_d = write_i;
          cnt_d   = '0;
          if (reject_in) begin
            // Rejected without touching the bus.
            done_d     = 1'b1;
            err_d      = 1'b1;
            err_code_d = 2'b11;
          end else begin
            busy_d     = 1'b1;
            req_d      = 1'b1;
            err_code_d = 2'b00;
            state_d    = S_REQ;
          end
        end
      end

      S_REQ: begin
        if (ctrl_grant_i) begin
          stb_d   = 1'b1;
          we_d    = write_q;
          adr_d   = addr_q[XLEN-1:OFS];
          sel_d   = sel_wide[BYTES-1:0];
          mdat_d  = dat_wide[XLEN-1:0];
          cnt_d   = '0;
          state_d = S_BEAT0;
        end
      end

      S_BEAT0, S_BEAT1: begin
        if (err_i) begin
          finish     = 1'b1;
          abort      = 1'b1;
          err_code_d = 2'b01;
        end else if (ack_i) begin
          if (state_q == S_BEAT0 && cross_q) begin
            // Second beat follows immediately; stb stays high.
            lo_d    = master_dat_i;
            adr_d   = adr_q + AW'(1);
            sel_d   = sel_wide[MW-1:BYTES];
            mdat_d  = dat_wide[2*XLEN-1:XLEN];
            cnt_d   = '0;
            state_d = S_BEAT1;
          end else begin
            finish     = 1'b1;
            err_code_d = 2'b00;
            if (!write_q) data_o_d = load_val;
          end
        end else if (TIMEOUT_CYCLES != 0 && cnt_inc == TO_VAL) begin
          finish     = 1'b1;
          abort      = 1'b1;
          err_code_d = 2'b10;
        end else begin
          cnt_d = cnt_inc[CW-1:0];
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      stb_d   = 1'b0;
      we_d    = 1'b0;
      sel_d   = '0;
      req_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      err_d   = abort;
      cnt_d   = '0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      write_q    <= 1'b0;
      lo_q       <= '0;
      cnt_q      <= '0;
      data_o_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      mdat_q     <= '0;
      adr_q      <= '0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      write_q    <= write_d;
      lo_q       <= lo_d;
      cnt_q      <= cnt_d;
      data_o_q   <= data_o_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      mdat_q     <= mdat_d;
      adr_q      <= adr_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      req_q      <= req_d;
    end
  end

  assign data_o       = data_o_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;
  assign master_dat_o = mdat_q;
  assign adr_o        = adr_q;
  assign cyc_o        = stb_q;
  assign stb_o        = stb_q;
  assign we_o         = we_q;
  assign sel_o        = sel_q;
  assign ctrl_req_o   = req_q;

endmodule
